// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg
//   Shared types and defaults for the register file request sequencer.
//   - ADDR_W_DEF / DATA_W_DEF : default address and word widths (8 x 8 file)
//   - prio_e                  : round-robin priority side used by the arbiter
//   - rsp_t                   : one read response (data word + error flag)
package regfile_seq_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    PRIO_READ  = 1'b0,
    PRIO_WRITE = 1'b1
  } prio_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  error;
  } rsp_t;

endpackage

// File: rtl/regfile_req_sequencer_rsp_fifo.sv
// rsp_fifo
//   Synchronous FIFO for read responses. The output is read directly from the
//   head entry, so a push into an empty FIFO becomes visible the next cycle and
//   the head stays stable until it is popped.
//   Ports:
//     clk, resetn       clock, asynchronous active-low reset
//     push, push_item   write one entry (ignored when full)
//     pop, pop_item     remove head entry (ignored when empty); pop_item = head
//     full, empty       status flags
//     count             current occupancy (0..DEPTH)
import regfile_seq_pkg::*;

module rsp_fifo #(
  parameter int  DEPTH  = 4,
  parameter type item_t = rsp_t
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  item_t                      push_item,
  input  logic                       pop,
  output item_t                      pop_item,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits match.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  item_t          mem_q [DEPTH];
  logic           push_ok;
  logic           pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
    pop_item = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_item;
    end
  end

endmodule

// File: rtl/regfile_req_sequencer.sv
// regfile_req_sequencer
//   Front end for a 1RW register file. Round-robin arbitrates a write request
//   channel against a read request channel, issues at most one registered
//   register-file operation per cycle, and collects read data into a
//   credit-protected response FIFO returned in issue order.
//   Ports:
//     clk, resetn                   clock, asynchronous active-low reset
//     w_valid/w_ready/w_addr/w_data write request handshake
//     r_valid/r_ready/r_addr        read request handshake
//     rf_wr/rf_rd/rf_addr/rf_din    registered register-file command
//     rf_dout/rf_error              read data/error, valid the cycle after rf_rd
//     rsp_valid/rsp_ready           response handshake
//     rsp_data/rsp_error            response payload
import regfile_seq_pkg::*;

module regfile_req_sequencer #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              rf_wr,
  output logic              rf_rd,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout,
  input  logic              rf_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error
);

  localparam int CRED_W = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              error;
  } rsp_item_t;

  prio_e             prio_q, prio_d;
  logic              rf_wr_q, rf_wr_d;
  logic              rf_rd_q, rf_rd_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_din_q, rf_din_d;
  logic              rd_stage1_q, rd_stage1_d;
  logic [CRED_W-1:0] credits_q, credits_d;

  logic              read_ok;
  logic              grant_w;
  logic              grant_r;
  logic              rsp_pop;
  rsp_item_t         push_item;
  rsp_item_t         head_item;
  logic              fifo_full;
  logic              fifo_empty;
  logic [$clog2(RSP_DEPTH):0] fifo_count;

  // Arbiter and next-state logic
  always_comb begin
    grant_w     = 1'b0;
    grant_r     = 1'b0;
    prio_d      = prio_q;
    // A read only competes while a response slot is guaranteed for it.
    read_ok     = r_valid && (credits_q != '0);

    if (w_valid && read_ok) begin
      if (prio_q == PRIO_READ) begin
        grant_r = 1'b1;
        prio_d  = PRIO_WRITE;
      end else begin
        grant_w = 1'b1;
        prio_d  = PRIO_READ;
      end
    end else if (w_valid) begin
      grant_w = 1'b1;
    end else if (read_ok) begin
      grant_r = 1'b1;
    end

    w_ready     = grant_w;
    r_ready     = grant_r;

    rf_wr_d     = grant_w;
    rf_rd_d     = grant_r;
    rf_addr_d   = grant_w ? w_addr : (grant_r ? r_addr : rf_addr_q);
    rf_din_d    = grant_w ? w_data : rf_din_q;
    // rf_dout is valid one cycle after rf_rd; this stage marks that cycle.
    rd_stage1_d = rf_rd_q;

    rsp_pop     = rsp_valid && rsp_ready;
    credits_d   = credits_q;
    if (grant_r && !rsp_pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!grant_r && rsp_pop) begin
      credits_d = credits_q + CRED_W'(1);
    end

    push_item.data  = rf_dout;
    push_item.error = rf_error;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_q      <= PRIO_READ;
      rf_wr_q     <= 1'b0;
      rf_rd_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_din_q    <= '0;
      rd_stage1_q <= 1'b0;
      credits_q   <= CRED_W'(RSP_DEPTH);
    end else begin
      prio_q      <= prio_d;
      rf_wr_q     <= rf_wr_d;
      rf_rd_q     <= rf_rd_d;
      rf_addr_q   <= rf_addr_d;
      rf_din_q    <= rf_din_d;
      rd_stage1_q <= rd_stage1_d;
      credits_q   <= credits_d;
    end
  end

  rsp_fifo #(
    .DEPTH  (RSP_DEPTH),
    .item_t (rsp_item_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rd_stage1_q),
    .push_item (push_item),
    .pop       (rsp_ready),
    .pop_item  (head_item),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rf_wr     = rf_wr_q;
  assign rf_rd     = rf_rd_q;
  assign rf_addr   = rf_addr_q;
  assign rf_din    = rf_din_q;
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head_item.data;
  assign rsp_error = head_item.error;

  // Every slot is either a free credit, a read in the issue pipeline, or a
  // stored response; the FIFO therefore never sees a push while full.
  a_credit_balance: assert property (@(posedge clk) disable iff (!resetn)
    int'(credits_q) + int'(fifo_count) + int'(rf_rd_q) + int'(rd_stage1_q) == RSP_DEPTH);
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(rd_stage1_q && fifo_full));

endmodule

// File: tb/tb_regfile_req_sequencer.sv
module tb_regfile_req_sequencer;

  logic       clk;
  logic       resetn;
  logic       w_valid;
  logic       w_ready;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       r_valid;
  logic       r_ready;
  logic [2:0] r_addr;
  logic       rf_wr;
  logic       rf_rd;
  logic [2:0] rf_addr;
  logic [7:0] rf_din;
  logic [7:0] rf_dout;
  logic       rf_error;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_error;

  int checks = 0;
  int errors = 0;

  regfile_req_sequencer #(
    .ADDR_W    (3),
    .DATA_W    (8),
    .RSP_DEPTH (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_addr    (r_addr),
    .rf_wr     (rf_wr),
    .rf_rd     (rf_rd),
    .rf_addr   (rf_addr),
    .rf_din    (rf_din),
    .rf_dout   (rf_dout),
    .rf_error  (rf_error),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reads of never-written addresses return 0 with error.
  logic [7:0] model_mem [8];
  logic       model_written [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      model_mem[i]     = 8'h00;
      model_written[i] = 1'b0;
    end
    rf_dout  = 8'h00;
    rf_error = 1'b0;
  end

  always @(posedge clk) begin
    if (rf_wr) begin
      model_mem[rf_addr]     <= rf_din;
      model_written[rf_addr] <= 1'b1;
    end
    if (rf_rd) begin
      rf_dout  <= model_written[rf_addr] ? model_mem[rf_addr] : 8'h00;
      rf_error <= !model_written[rf_addr];
    end
  end

  task automatic apply_reset();
    resetn = 1'b0;
    w_valid = 1'b0; r_valid = 1'b0; rsp_ready = 1'b0;
    w_addr = '0; w_data = '0; r_addr = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    w_valid = 1'b0; r_valid = 1'b0; rsp_ready = 1'b0;
    w_addr = '0; w_data = '0; r_addr = '0;
    @(negedge clk); #1;
    checks++;
    if ({rf_wr, rf_rd, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got wr/rd/rsp_valid=%b expected 000", {rf_wr, rf_rd, rsp_valid});
    end
    checks++;
    if ({rf_addr, rf_din} !== 11'h000) begin
      errors++; $display("FAIL reset_addr_din: got addr=%h din=%h expected 0/00", rf_addr, rf_din);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if ({w_ready, r_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready_idle: got w_ready/r_ready=%b expected 00", {w_ready, r_ready});
    end
    @(negedge clk); #1;
    checks++;
    if ({rf_wr, rf_rd, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle: got wr/rd/rsp_valid=%b expected 000", {rf_wr, rf_rd, rsp_valid});
    end
    $display("test_reset done");
  endtask

  task automatic test_write_then_read();
    apply_reset();
    w_valid = 1'b1; w_addr = 3'd3; w_data = 8'hA5; #1;
    checks++;
    if (w_ready !== 1'b1) begin
      errors++; $display("FAIL wr_grant: got w_ready=%b expected 1", w_ready);
    end
    @(negedge clk);
    w_valid = 1'b0; r_valid = 1'b1; r_addr = 3'd3; #1;
    checks++;
    if (r_ready !== 1'b1) begin
      errors++; $display("FAIL rd_grant: got r_ready=%b expected 1", r_ready);
    end
    checks++;
    if ({rf_wr, rf_rd, rf_addr, rf_din} !== {1'b1, 1'b0, 3'd3, 8'hA5}) begin
      errors++; $display("FAIL wr_issue: got wr=%b rd=%b addr=%h din=%h expected 1 0 3 a5", rf_wr, rf_rd, rf_addr, rf_din);
    end
    @(negedge clk);
    r_valid = 1'b0; #1;
    checks++;
    if ({rf_wr, rf_rd, rf_addr, rsp_valid} !== {1'b0, 1'b1, 3'd3, 1'b0}) begin
      errors++; $display("FAIL rd_issue: got wr=%b rd=%b addr=%h rsp_valid=%b expected 0 1 3 0", rf_wr, rf_rd, rf_addr, rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({rf_rd, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL rd_latency_n2: got rf_rd=%b rsp_valid=%b expected 0 0", rf_rd, rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL rd_response: got valid=%b data=%h err=%b expected 1 a5 0", rsp_valid, rsp_data, rsp_error);
    end
    checks++;
    if (rf_din !== 8'hA5) begin
      errors++; $display("FAIL din_hold: got rf_din=%h expected a5", rf_din);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_pop: got rsp_valid=%b expected 0", rsp_valid);
    end
    $display("test_write_then_read done");
  endtask

  task automatic test_alternate();
    int got;
    logic exp_r;
    apply_reset();
    w_valid = 1'b1; r_valid = 1'b1; w_addr = 3'd3; w_data = 8'hA5; r_addr = 3'd3;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_r = (i % 2 == 0);
      checks++;
      if ({r_ready, w_ready} !== {exp_r, !exp_r}) begin
        errors++; $display("FAIL alt_grant_%0d: got r/w ready=%b%b expected %b%b", i, r_ready, w_ready, exp_r, !exp_r);
      end
      checks++;
      if ((rf_wr && rf_rd) !== 1'b0) begin
        errors++; $display("FAIL alt_overlap_%0d: got rf_wr&rf_rd=1 expected 0", i);
      end
      @(negedge clk);
    end
    w_valid = 1'b0; r_valid = 1'b0;
    rsp_ready = 1'b1;
    got = 0;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (rsp_valid) got++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++; $display("FAIL alt_rsp_count: got %0d responses expected 3", got);
    end
    $display("test_alternate done");
  endtask

  task automatic test_credit_stall();
    int acc;
    int got;
    logic exp_r;
    apply_reset();
    r_valid = 1'b1; r_addr = 3'd3; rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_r = (i < 4);
      checks++;
      if (r_ready !== exp_r) begin
        errors++; $display("FAIL credit_rd_%0d: got r_ready=%b expected %b", i, r_ready, exp_r);
      end
      if (r_ready) acc++;
      @(negedge clk);
    end
    checks++;
    if (acc !== 4) begin
      errors++; $display("FAIL credit_accepted: got %0d reads expected 4", acc);
    end
    w_valid = 1'b1; w_addr = 3'd7; w_data = 8'h77; #1;
    checks++;
    if ({w_ready, r_ready} !== 2'b10) begin
      errors++; $display("FAIL credit_write_passes: got w/r ready=%b%b expected 10", w_ready, r_ready);
    end
    @(negedge clk);
    w_valid = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL credit_fifo_has_rsp: got rsp_valid=%b expected 1", rsp_valid);
    end
    rsp_ready = 1'b1; #1;
    checks++;
    if (r_ready !== 1'b0) begin
      errors++; $display("FAIL credit_pop_same_cycle: got r_ready=%b expected 0", r_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b0; #1;
    checks++;
    if (r_ready !== 1'b1) begin
      errors++; $display("FAIL credit_returned: got r_ready=%b expected 1", r_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (r_ready !== 1'b0) begin
      errors++; $display("FAIL credit_reexhausted: got r_ready=%b expected 0", r_ready);
    end
    r_valid = 1'b0;
    rsp_ready = 1'b1;
    got = 0;
    for (int j = 0; j < 10; j++) begin
      #1;
      if (rsp_valid) got++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (got !== 4) begin
      errors++; $display("FAIL credit_drain: got %0d responses expected 4", got);
    end
    $display("test_credit_stall done");
  endtask

  task automatic test_ordering();
    int got;
    logic [7:0] exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1; w_addr = 3'(i); w_data = 8'(8'h10 + i); #1;
      checks++;
      if (w_ready !== 1'b1) begin
        errors++; $display("FAIL preload_grant_%0d: got w_ready=%b expected 1", i, w_ready);
      end
      if (i > 0) begin
        checks++;
        if ({rf_wr, rf_addr} !== {1'b1, 3'(i - 1)}) begin
          errors++; $display("FAIL preload_b2b_%0d: got rf_wr=%b addr=%h expected 1 %h", i, rf_wr, rf_addr, 3'(i - 1));
        end
      end
      @(negedge clk);
    end
    w_valid = 1'b0;
    r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_addr = 3'(i); #1;
      checks++;
      if (r_ready !== 1'b1) begin
        errors++; $display("FAIL order_rd_grant_%0d: got r_ready=%b expected 1", i, r_ready);
      end
      if (i > 0) begin
        checks++;
        if ({rf_rd, rf_addr} !== {1'b1, 3'(i - 1)}) begin
          errors++; $display("FAIL order_rd_b2b_%0d: got rf_rd=%b addr=%h expected 1 %h", i, rf_rd, rf_addr, 3'(i - 1));
        end
      end
      @(negedge clk);
    end
    r_valid = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      rsp_ready = (cyc % 2 == 0); #1;
      if (rsp_valid) begin
        exp_d = 8'(8'h10 + got);
        checks++;
        if ({rsp_data, rsp_error} !== {exp_d, 1'b0}) begin
          errors++; $display("FAIL order_rsp_%0d: got data=%h err=%b expected %h 0", got, rsp_data, rsp_error, exp_d);
        end
        if (rsp_ready) got++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (got !== 4) begin
      errors++; $display("FAIL order_count: got %0d responses expected 4", got);
    end
    $display("test_ordering done");
  endtask

  task automatic test_error();
    logic seen;
    apply_reset();
    r_valid = 1'b1; r_addr = 3'd5; #1;
    checks++;
    if (r_ready !== 1'b1) begin
      errors++; $display("FAIL err_rd_grant: got r_ready=%b expected 1", r_ready);
    end
    @(negedge clk);
    r_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL err_rsp_timeout: got no response expected one within 8 cycles");
    end
    checks++;
    if ({rsp_data, rsp_error} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL err_passthrough: got data=%h err=%b expected 00 1", rsp_data, rsp_error);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("test_error done");
  endtask

  task automatic test_reset_mid();
    logic stale;
    int acc;
    apply_reset();
    r_valid = 1'b1; r_addr = 3'd0;
    @(negedge clk);
    r_addr = 3'd1;
    @(negedge clk);
    r_valid = 1'b0;
    resetn = 1'b0; #1;
    checks++;
    if ({rf_rd, rsp_valid, rf_addr} !== {1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL midrst_async_clear: got rf_rd=%b rsp_valid=%b addr=%h expected 0 0 0", rf_rd, rsp_valid, rf_addr);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp_valid) stale = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL midrst_stale_rsp: got rsp_valid=1 after release expected 0");
    end
    r_valid = 1'b1; r_addr = 3'd2;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (r_ready) acc++;
      @(negedge clk);
    end
    r_valid = 1'b0;
    checks++;
    if (acc !== 4) begin
      errors++; $display("FAIL midrst_credits: got %0d reads accepted expected 4", acc);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_alternate();
    test_credit_stall();
    test_ordering();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_req_sequencer.md
Name: regfile_req_sequencer

Overview:
- Upstream front end for the 8x8 1RW flip-flop register file.
- Accepts independent write and read request channels, each with a valid/ready handshake.
- Arbitrates between them round-robin and issues at most one operation per cycle, so rf_wr and rf_rd are never asserted together.
- Captures read data one cycle after issue into a credit-protected response FIFO with its own valid/ready output.

Parameters:
- ADDR_W, 3, register file address width (8 entries).
- DATA_W, 8, word width.
- RSP_DEPTH, 4, response FIFO entries; minimum 2; power of two.

Ports:
- clk  input  1  clock, all flops on posedge.
- resetn  input  1  asynchronous active-low reset.
- w_valid  input  1  write request valid.
- w_ready  output  1  write request accepted this cycle.
- w_addr  input  ADDR_W  write address.
- w_data  input  DATA_W  write data.
- r_valid  input  1  read request valid.
- r_ready  output  1  read request accepted this cycle.
- r_addr  input  ADDR_W  read address.
- rf_wr  output  1  register file write strobe, registered.
- rf_rd  output  1  register file read strobe, registered.
- rf_addr  output  ADDR_W  register file address, registered.
- rf_din  output  DATA_W  register file write data, registered.
- rf_dout  input  DATA_W  register file read data, valid the cycle after rf_rd.
- rf_error  input  1  register file error flag, sampled with rf_dout.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  DATA_W  read data, in issue order.
- rsp_error  output  1  error flag captured with this response.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert) clears everything:
  - rf_wr=0, rf_rd=0, rf_addr=0, rf_din=0, rsp_valid=0.
  - FIFO empty; credits=RSP_DEPTH; prio=READ; both in-flight flags cleared.
  - Reads in flight when reset asserts are dropped, with no response.
- Read eligibility: read_ok = r_valid && credits!=0.
- Grant (combinational) when both w_valid and read_ok are true:
  - Grant goes to the prio side; prio then flips to the other side.
  - A single requester is granted without changing prio.
- w_ready = write granted. r_ready = read granted. Neither ready depends on rsp_ready, apart from the credit gate on reads.
- Issue stage: on a handshake in cycle N, rf_wr or rf_rd is high for exactly cycle N+1 with the captured rf_addr/rf_din. rf_din holds its last value on reads.
- Back-to-back handshakes give one rf strobe per cycle, with no bubble.
- Pipeline tracking: rd_stage1 = rf_rd registered. In cycle N+2, rf_dout and rf_error are pushed into the FIFO.
- Read latency: handshake in N -> rsp_valid in N+3 if the FIFO was empty.
- Credits:
  - Decrement on read handshake; increment on response pop (rsp_valid && rsp_ready).
  - Same-cycle handshake and pop leave credits unchanged.
  - credits = RSP_DEPTH - (FIFO occupancy + reads in flight), so the FIFO can never overflow.
- FIFO:
  - Pointers are ADDR bits plus a wrap bit; full and empty are distinguished by the wrap bit.
  - Push and pop in the same cycle is allowed when non-empty.
  - Empty plus push: rsp_valid rises the next cycle (no fall-through).
- Responses are returned strictly in read-issue order. No ordering is enforced between the write and read channels beyond issue order.
- rsp_data/rsp_error are stable while rsp_valid && !rsp_ready.
- Writes are never stalled by the response path.

Decomposition:
- Package regfile_seq_pkg holds:
  - ADDR_W and DATA_W defaults.
  - enum prio_e {PRIO_READ, PRIO_WRITE}.
  - struct rsp_t {data, error}.
- One sub-module: rsp_fifo (parameterised sync FIFO of rsp_t, with push/pop/full/empty/count).
- Arbiter, issue registers and credit counter stay in the top module.

Test Plan:
- Write then read: w_addr=3, w_data=0xA5; next cycle r_addr=3.
  - rf_wr in cycle 1 and rf_rd in cycle 2, never overlapping.
  - rsp_data=0xA5, rsp_error=0, rsp_valid 3 cycles after the read handshake.
- Simultaneous w_valid and r_valid for 6 cycles after reset:
  - Grants alternate R,W,R,W,R,W.
  - rf_wr&&rf_rd is never 1.
- Credit stall: rsp_ready=0, 6 reads offered.
  - Exactly 4 are accepted; r_ready=0 thereafter.
  - Raising rsp_ready for one cycle admits exactly one more read.
- Ordering and stall: reads of addr 0..3 with preloaded 0x10..0x13; rsp_ready toggled 1010.
  - Responses 0x10,0x11,0x12,0x13 in order, each held stable while stalled.
- Error passthrough: model rf_error=1 with rf_dout=0 on a read of an unwritten address.
  - Response carries rsp_error=1, rsp_data=0x00.
- Reset mid-operation: assert resetn=0 with 2 reads in flight.
  - Asynchronous clear; rsp_valid=0 immediately; credits=4; no stale response after release.
